// File: rtl/rggen_rtl_pkg.sv
// Shared status and access-state types for the register bus front end.
package rggen_rtl_pkg;

    typedef enum logic [1:0] {
        RGGEN_OKAY         = 2'b00,
        RGGEN_EXOKAY       = 2'b01,
        RGGEN_SLAVE_ERROR  = 2'b10,
        RGGEN_DECODE_ERROR = 2'b11
    } rggen_status;

    typedef enum logic [1:0] {
        RGGEN_IDLE     = 2'b00,
        RGGEN_ACCESS   = 2'b01,
        RGGEN_RESPONSE = 2'b10
    } rggen_access_state;

endpackage

// File: rtl/rggen_or_reducer.sv
// Bitwise OR of COUNT packed WIDTH-bit words; combinational.
module rggen_or_reducer #(
    parameter int WIDTH = 32,
    parameter int COUNT = 1
) (
    input  logic [WIDTH*COUNT-1:0] i_data,
    output logic [WIDTH-1:0]       o_data
);

    always_comb begin
        o_data = '0;
        for (int i = 0; i < COUNT; i++) begin
            o_data = o_data | i_data[WIDTH*i+:WIDTH];
        end
    end

endmodule

// File: rtl/rggen_bus_access_controller.sv
// Single-outstanding bus front end: broadcasts one captured request to all registers,
// waits for a ready slot, decode miss or timeout, then holds a registered response until consumed.
module rggen_bus_access_controller
    import rggen_rtl_pkg::*;
#(
    parameter int                     ADDRESS_WIDTH     = 8,
    parameter int                     BUS_WIDTH         = 32,
    parameter int                     REGISTERS         = 1,
    parameter bit                     PRE_DECODE        = 0,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS    = '0,
    parameter int                     BYTE_SIZE         = 256,
    parameter bit                     ERROR_STATUS      = 0,
    parameter logic [BUS_WIDTH-1:0]   DEFAULT_READ_DATA = '0,
    parameter int                     TIMEOUT_CYCLES    = 0
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_req_valid,
    output logic                           o_req_ready,
    input  logic                           i_req_write,
    input  logic [ADDRESS_WIDTH-1:0]       i_req_address,
    input  logic [BUS_WIDTH/8-1:0]         i_req_strobe,
    input  logic [BUS_WIDTH-1:0]           i_req_write_data,
    output logic                           o_rsp_valid,
    input  logic                           i_rsp_ready,
    output logic [1:0]                     o_rsp_status,
    output logic [BUS_WIDTH-1:0]           o_rsp_read_data,
    output logic                           o_register_valid,
    output logic                           o_register_write,
    output logic [ADDRESS_WIDTH-1:0]       o_register_address,
    output logic [BUS_WIDTH/8-1:0]         o_register_strobe,
    output logic [BUS_WIDTH-1:0]           o_register_write_data,
    input  logic [REGISTERS-1:0]           i_register_active,
    input  logic [REGISTERS-1:0]           i_register_ready,
    input  logic [2*REGISTERS-1:0]         i_register_status,
    input  logic [BUS_WIDTH*REGISTERS-1:0] i_register_read_data
);

    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TIMEOUT_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDRESS_WIDTH:0] WINDOW_END =
        {1'b0, BASE_ADDRESS} + (ADDRESS_WIDTH + 1)'(BYTE_SIZE);
    localparam rggen_status MISS_STATUS = ERROR_STATUS ? RGGEN_SLAVE_ERROR : RGGEN_OKAY;

    rggen_access_state          state;
    logic [CW-1:0]              counter;
    rggen_status                rsp_status;
    logic [REGISTERS-1:0]       hit_mask;
    logic [2*REGISTERS-1:0]     masked_status;
    logic [BUS_WIDTH*REGISTERS-1:0] masked_data;
    logic [1:0]                 collected_status;
    logic [BUS_WIDTH-1:0]       collected_data;
    logic                       in_window;
    logic [BUS_WIDTH-1:0]       miss_data;

    assign hit_mask = i_register_active & i_register_ready;

    // Only slots that are both selected and done may contribute to the response.
    always_comb begin
        masked_status = '0;
        masked_data   = '0;
        for (int i = 0; i < REGISTERS; i++) begin
            masked_status[2*i+:2]                = i_register_status[2*i+:2] & {2{hit_mask[i]}};
            masked_data[BUS_WIDTH*i+:BUS_WIDTH] = i_register_read_data[BUS_WIDTH*i+:BUS_WIDTH]
                                                & {BUS_WIDTH{hit_mask[i]}};
        end
    end

    rggen_or_reducer #(.WIDTH(2), .COUNT(REGISTERS)) u_status_reducer (
        .i_data (masked_status),
        .o_data (collected_status)
    );

    rggen_or_reducer #(.WIDTH(BUS_WIDTH), .COUNT(REGISTERS)) u_data_reducer (
        .i_data (masked_data),
        .o_data (collected_data)
    );

    assign in_window = !PRE_DECODE ||
                       (({1'b0, i_req_address} >= {1'b0, BASE_ADDRESS}) &&
                        ({1'b0, i_req_address} <  WINDOW_END));
    assign miss_data = o_register_write ? '0 : DEFAULT_READ_DATA;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state                 <= RGGEN_IDLE;
            counter               <= '0;
            o_req_ready           <= 1'b1;
            o_register_valid      <= 1'b0;
            o_rsp_valid           <= 1'b0;
            rsp_status            <= RGGEN_OKAY;
            o_rsp_read_data       <= '0;
            o_register_write      <= 1'b0;
            o_register_address    <= '0;
            o_register_strobe     <= '0;
            o_register_write_data <= '0;
        end else begin
            case (state)
                RGGEN_IDLE: begin
                    if (i_req_valid) begin
                        o_register_write      <= i_req_write;
                        o_register_address    <= i_req_address;
                        o_register_strobe     <= i_req_strobe;
                        o_register_write_data <= i_req_write_data;
                        counter               <= '0;
                        o_req_ready           <= 1'b0;
                        if (in_window) begin
                            state            <= RGGEN_ACCESS;
                            o_register_valid <= 1'b1;
                        end else begin
                            state           <= RGGEN_RESPONSE;
                            o_rsp_valid     <= 1'b1;
                            rsp_status      <= MISS_STATUS;
                            o_rsp_read_data <= i_req_write ? '0 : DEFAULT_READ_DATA;
                        end
                    end
                end
                RGGEN_ACCESS: begin
                    if (|hit_mask) begin
                        state            <= RGGEN_RESPONSE;
                        o_register_valid <= 1'b0;
                        o_rsp_valid      <= 1'b1;
                        rsp_status       <= rggen_status'(collected_status);
                        o_rsp_read_data  <= o_register_write ? '0 : collected_data;
                    end else if (!(|i_register_active)) begin
                        state            <= RGGEN_RESPONSE;
                        o_register_valid <= 1'b0;
                        o_rsp_valid      <= 1'b1;
                        rsp_status       <= MISS_STATUS;
                        o_rsp_read_data  <= miss_data;
                    end else if ((TIMEOUT_CYCLES != 0) && (counter == TIMEOUT_LAST)) begin
                        state            <= RGGEN_RESPONSE;
                        o_register_valid <= 1'b0;
                        o_rsp_valid      <= 1'b1;
                        rsp_status       <= RGGEN_SLAVE_ERROR;
                        o_rsp_read_data  <= miss_data;
                    end else if (counter != '1) begin
                        counter <= counter + 1'b1;
                    end
                end
                RGGEN_RESPONSE: begin
                    if (i_rsp_ready) begin
                        state       <= RGGEN_IDLE;
                        o_rsp_valid <= 1'b0;
                        o_req_ready <= 1'b1;
                    end
                end
                default: begin
                    state            <= RGGEN_IDLE;
                    o_req_ready      <= 1'b1;
                    o_register_valid <= 1'b0;
                    o_rsp_valid      <= 1'b0;
                end
            endcase
        end
    end

    assign o_rsp_status = rsp_status;

    // Overlapping address maps are a configuration error; results would be OR-merged.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && (state == RGGEN_ACCESS)) begin
            assert ($onehot0(i_register_active))
                else $error("multiple register slots active");
        end
    end

endmodule

// File: tb/tb_rggen_bus_access_controller.sv
// Directed checks of the bus access controller: hit, miss, pre-decode, timeout, backpressure, reset.
module tb_rggen_bus_access_controller;

    localparam int AW = 12;
    localparam int BW = 32;
    localparam int RN = 2;
    localparam logic [BW-1:0] DEF = 32'hBAD0_BAD0;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_address;
    logic [BW/8-1:0] req_strobe;
    logic [BW-1:0] req_write_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_status;
    logic [BW-1:0] rsp_read_data;
    logic          reg_valid;
    logic          reg_write;
    logic [AW-1:0] reg_address;
    logic [BW/8-1:0] reg_strobe;
    logic [BW-1:0] reg_write_data;
    logic [RN-1:0] reg_active;
    logic [RN-1:0] reg_ready;
    logic [2*RN-1:0] reg_status;
    logic [BW*RN-1:0] reg_read_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rggen_bus_access_controller #(
        .ADDRESS_WIDTH     (AW),
        .BUS_WIDTH         (BW),
        .REGISTERS         (RN),
        .PRE_DECODE        (1),
        .BASE_ADDRESS      (12'h100),
        .BYTE_SIZE         (256),
        .ERROR_STATUS      (1),
        .DEFAULT_READ_DATA (DEF),
        .TIMEOUT_CYCLES    (4)
    ) dut (
        .i_clk                 (clk),
        .i_rst_n               (rst_n),
        .i_req_valid           (req_valid),
        .o_req_ready           (req_ready),
        .i_req_write           (req_write),
        .i_req_address         (req_address),
        .i_req_strobe          (req_strobe),
        .i_req_write_data      (req_write_data),
        .o_rsp_valid           (rsp_valid),
        .i_rsp_ready           (rsp_ready),
        .o_rsp_status          (rsp_status),
        .o_rsp_read_data       (rsp_read_data),
        .o_register_valid      (reg_valid),
        .o_register_write      (reg_write),
        .o_register_address    (reg_address),
        .o_register_strobe     (reg_strobe),
        .o_register_write_data (reg_write_data),
        .i_register_active     (reg_active),
        .i_register_ready      (reg_ready),
        .i_register_status     (reg_status),
        .i_register_read_data  (reg_read_data)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
            else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
            end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_address = '0;
        req_strobe = '0; req_write_data = '0; rsp_ready = 1'b1;
        reg_active = '0; reg_ready = '0; reg_status = '0; reg_read_data = '0;
        step(); step();
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_reg_valid", 32'(reg_valid), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_status", 32'(rsp_status), 32'd0);
        chk("rst_rdata", rsp_read_data, 32'h0);
        rst_n = 1'b1;
        step();

        // read hit on slot 1; slot 0 carries junk that must be masked
        req_valid = 1'b1; req_write = 1'b0; req_address = 12'h104;
        step();
        chk("rd_req_ready", 32'(req_ready), 32'd0);
        chk("rd_reg_valid", 32'(reg_valid), 32'd1);
        chk("rd_rsp_early", 32'(rsp_valid), 32'd0);
        chk("rd_reg_addr", 32'(reg_address), 32'h104);
        req_valid = 1'b0;
        reg_active = 2'b10; reg_ready = 2'b10;
        reg_status = {2'b00, 2'b10};
        reg_read_data = {32'hDEAD_BEEF, 32'h1111_1111};
        step();
        chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rd_status", 32'(rsp_status), 32'd0);
        chk("rd_rdata", rsp_read_data, 32'hDEAD_BEEF);
        chk("rd_reg_valid_off", 32'(reg_valid), 32'd0);
        reg_active = '0; reg_ready = '0;
        step();
        chk("rd_rsp_done", 32'(rsp_valid), 32'd0);
        chk("rd_idle_ready", 32'(req_ready), 32'd1);

        // write with no slot active: decode miss
        req_valid = 1'b1; req_write = 1'b1; req_address = 12'h140;
        req_strobe = 4'b0011; req_write_data = 32'h1234_5678;
        step();
        chk("wm_reg_write", 32'(reg_write), 32'd1);
        chk("wm_reg_strobe", 32'(reg_strobe), 32'h3);
        chk("wm_reg_wdata", reg_write_data, 32'h1234_5678);
        chk("wm_reg_valid", 32'(reg_valid), 32'd1);
        req_valid = 1'b0;
        step();
        chk("wm_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("wm_status", 32'(rsp_status), 32'd2);
        chk("wm_rdata", rsp_read_data, 32'h0);
        chk("wm_reg_valid_off", 32'(reg_valid), 32'd0);
        step();
        chk("wm_no_second_valid", 32'(rsp_valid), 32'd0);

        // pre-decode rejection below the window
        req_valid = 1'b1; req_write = 1'b0; req_address = 12'h0FC;
        step();
        chk("pd_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("pd_reg_valid", 32'(reg_valid), 32'd0);
        chk("pd_status", 32'(rsp_status), 32'd2);
        chk("pd_rdata", rsp_read_data, DEF);
        req_valid = 1'b0;
        step();
        chk("pd_rsp_done", 32'(rsp_valid), 32'd0);
        chk("pd_reg_valid_after", 32'(reg_valid), 32'd0);

        // timeout: slot 0 active but never ready, response held under backpressure
        req_valid = 1'b1; req_write = 1'b0; req_address = 12'h108;
        reg_active = 2'b01; reg_ready = 2'b00;
        reg_read_data = {32'h0, 32'h5555_5555};
        rsp_ready = 1'b0;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to_reg_valid_%0d", i), 32'(reg_valid), 32'd1);
            chk($sformatf("to_rsp_early_%0d", i), 32'(rsp_valid), 32'd0);
            step();
        end
        chk("to_reg_valid_off", 32'(reg_valid), 32'd0);
        req_valid = 1'b1; req_address = 12'h10C;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_rsp_valid_%0d", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp_status_%0d", i), 32'(rsp_status), 32'd2);
            chk($sformatf("bp_rdata_%0d", i), rsp_read_data, DEF);
            chk($sformatf("bp_req_ready_%0d", i), 32'(req_ready), 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_rsp_done", 32'(rsp_valid), 32'd0);
        chk("bp_idle_ready", 32'(req_ready), 32'd1);
        chk("bp_not_yet_accepted", 32'(reg_valid), 32'd0);
        step();
        chk("bp_next_accepted", 32'(reg_valid), 32'd1);
        chk("bp_next_addr", 32'(reg_address), 32'h10C);

        // reset while stalled in ACCESS
        req_valid = 1'b0; reg_active = 2'b01; reg_ready = 2'b00;
        rst_n = 1'b0;
        step();
        chk("ra_reg_valid", 32'(reg_valid), 32'd0);
        chk("ra_req_ready", 32'(req_ready), 32'd1);
        chk("ra_rsp_valid", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1; reg_active = '0;
        step();
        chk("ra_no_rsp", 32'(rsp_valid), 32'd0);

        // normal read after reset, slot 0 with EXOKAY
        req_valid = 1'b1; req_write = 1'b0; req_address = 12'h100;
        step();
        req_valid = 1'b0;
        reg_active = 2'b01; reg_ready = 2'b01;
        reg_status = {2'b10, 2'b01};
        reg_read_data = {32'h7777_7777, 32'hCAFE_F00D};
        step();
        chk("pr_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("pr_status", 32'(rsp_status), 32'd1);
        chk("pr_rdata", rsp_read_data, 32'hCAFE_F00D);
        reg_active = '0; reg_ready = '0;
        step();
        chk("pr_rsp_done", 32'(rsp_valid), 32'd0);

        // write hit: read data forced to zero
        req_valid = 1'b1; req_write = 1'b1; req_address = 12'h100;
        req_strobe = 4'hF; req_write_data = 32'hA5A5_A5A5;
        step();
        req_valid = 1'b0;
        reg_active = 2'b01; reg_ready = 2'b01;
        reg_status = {2'b00, 2'b00};
        step();
        chk("wh_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("wh_status", 32'(rsp_status), 32'd0);
        chk("wh_rdata", rsp_read_data, 32'h0);
        reg_active = '0; reg_ready = '0;
        step();
        chk("wh_rsp_done", 32'(rsp_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
